// File: rtl/ts_packet_arbiter.sv
// ts_packet_arbiter
// Weighted round-robin scheduler for the multi-channel TS muxer. Picks the next
// per-channel packet buffer to read, issues its one-cycle packet request and
// generates the byte-qualified select / valid / sync strobes for the 188-byte
// output packet. All outputs come straight from flops.
//
// Optional feature: define NULL_PKT_INSERT_EN to insert null packets after
// NULL_GAP idle arbitration cycles. Without it NULL_PKT and NULL_DATA are 0.
module ts_packet_arbiter #(
    parameter int N_CH     = 4,
    parameter int PKT_LEN  = 188,
    parameter int W_BITS   = 4,
    parameter int RD_LAT   = 2,
    parameter int NULL_GAP = 376,
    localparam int SEL_W   = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                   SYS_CLK,
    input  logic                   RST,
    input  logic [N_CH-1:0]        CH_EN,
    input  logic [N_CH*W_BITS-1:0] WEIGHT,
    input  logic [N_CH-1:0]        GOT_FULL_PACKET,
    input  logic                   OUT_READY,
    output logic [N_CH-1:0]        GIVE_ME_ONE_PACKET,
    output logic [SEL_W-1:0]       SEL,
    output logic                   D_VALID_OUT,
    output logic                   P_SYNC_OUT,
    output logic                   NULL_PKT,
    output logic [7:0]             NULL_DATA
);

    localparam int CNT_W  = $clog2(PKT_LEN);
    localparam int WAIT_W = (RD_LAT > 2) ? $clog2(RD_LAT) : 1;

    // The buffer read latency must leave room for the REQ cycle.
    if (RD_LAT < 1 || NULL_GAP < 1) begin : g_param_check
        $error("ts_packet_arbiter: RD_LAT and NULL_GAP must be >= 1");
    end

    typedef enum logic [2:0] {
        ST_ARB,
        ST_REQ,
        ST_WAIT,
        ST_XFER,
        ST_GAP
    } state_t;

    state_t              state_q, state_d;
    logic [SEL_W-1:0]    owner_q, owner_d;
    logic                owner_vld_q, owner_vld_d;   // no grant since reset -> scan starts at 0
    logic [W_BITS-1:0]   credit_q, credit_d;
    logic [CNT_W-1:0]    byte_q, byte_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;

    logic [N_CH-1:0]     elig;
    logic                keep_owner;
    logic                scan_hit;
    logic [SEL_W-1:0]    scan_ch;
    int                  scan_start;
    logic [W_BITS-1:0]   w_raw;
    logic [W_BITS-1:0]   credit_load;
    logic [N_CH-1:0]     give_d;
    logic                null_act;
    logic [7:0]          null_byte;

`ifdef NULL_PKT_INSERT_EN
    localparam int IDLE_W = $clog2(NULL_GAP + 1);
    logic                null_q, null_d;
    logic [IDLE_W-1:0]   idle_q, idle_d;
`endif

    assign elig        = CH_EN & GOT_FULL_PACKET;
    assign keep_owner  = owner_vld_q && elig[owner_q] && (credit_q != '0);
    assign scan_start  = owner_vld_q ? ((int'(owner_q) + 1) % N_CH) : 0;
    assign w_raw       = WEIGHT[int'(scan_ch)*W_BITS +: W_BITS];
    assign credit_load = (w_raw == '0) ? W_BITS'(1) : w_raw;
    assign SEL         = owner_q;

    // Find the first eligible channel at or after the scan start, wrapping.
    always_comb begin
        scan_hit = 1'b0;
        scan_ch  = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (!scan_hit && elig[SEL_W'((scan_start + k) % N_CH)]) begin
                scan_hit = 1'b1;
                scan_ch  = SEL_W'((scan_start + k) % N_CH);
            end
        end
    end

    // Next-state logic for the scheduling FSM and its counters.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
        state_d     = state_q;
        owner_d     = owner_q;
        owner_vld_d = owner_vld_q;
        credit_d    = credit_q;
        byte_d      = byte_q;
        wait_d      = wait_q;
`ifdef NULL_PKT_INSERT_EN
        null_d      = null_q;
        idle_d      = idle_q;
`endif
        case (state_q)
            ST_ARB: begin
                if (OUT_READY && (keep_owner || scan_hit)) begin
                    state_d = ST_REQ;
                    if (!keep_owner) begin
                        owner_d     = scan_ch;
                        owner_vld_d = 1'b1;
                        credit_d    = credit_load;
                    end
`ifdef NULL_PKT_INSERT_EN
                    idle_d = '0;
`endif
                end
`ifdef NULL_PKT_INSERT_EN
                else if (OUT_READY) begin
                    // Idle long enough: emit a null packet; owner and credit stay.
                    if (idle_q == IDLE_W'(NULL_GAP - 1)) begin
                        idle_d  = '0;
                        null_d  = 1'b1;
                        byte_d  = '0;
                        state_d = ST_XFER;
                    end else begin
                        idle_d = idle_q + 1'b1;
                    end
                end
`endif
            end
            ST_REQ: begin
                credit_d = credit_q - 1'b1;
                byte_d   = '0;
                wait_d   = '0;
                state_d  = (RD_LAT == 1) ? ST_XFER : ST_WAIT;
            end
            ST_WAIT: begin
                if (wait_q == WAIT_W'(RD_LAT - 2)) begin
                    state_d = ST_XFER;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            ST_XFER: begin
                if (byte_q == CNT_W'(PKT_LEN - 1)) begin
                    state_d = ST_GAP;
                end else begin
                    byte_d = byte_q + 1'b1;
                end
            end
            ST_GAP: begin
                state_d = ST_ARB;
`ifdef NULL_PKT_INSERT_EN
                null_d  = 1'b0;
`endif
            end
            default: state_d = ST_ARB;
        endcase
    end

    // Decode the registered outputs from the next state so they align with it.
    always_comb begin
        give_d = '0;
        if (state_d == ST_REQ) begin
            give_d[owner_d] = 1'b1;
        end
`ifdef NULL_PKT_INSERT_EN
        null_act = null_d && (state_d == ST_XFER);
`else
        null_act = 1'b0;
`endif
        case (byte_d)
            CNT_W'(0): null_byte = 8'h47;
            CNT_W'(1): null_byte = 8'h1F;
            CNT_W'(3): null_byte = 8'h10;
            default:   null_byte = 8'hFF;
        endcase
    end

    // FSM state, owner, credit and counter registers.
    always_ff @(posedge SYS_CLK or negedge RST) begin
        if (!RST) begin
            // NOTE: sequential state uses non-blocking assignments so all flops update together.
            state_q     <= ST_ARB;
            owner_q     <= '0;
            owner_vld_q <= 1'b0;
            credit_q    <= '0;
            byte_q      <= '0;
            wait_q      <= '0;
`ifdef NULL_PKT_INSERT_EN
            null_q      <= 1'b0;
            idle_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            owner_vld_q <= owner_vld_d;
            credit_q    <= credit_d;
            byte_q      <= byte_d;
            wait_q      <= wait_d;
`ifdef NULL_PKT_INSERT_EN
            null_q      <= null_d;
            idle_q      <= idle_d;
`endif
        end
    end

    // Output registers; reset forces every strobe low at once.
    always_ff @(posedge SYS_CLK or negedge RST) begin
        if (!RST) begin
            GIVE_ME_ONE_PACKET <= '0;
            D_VALID_OUT        <= 1'b0;
            P_SYNC_OUT         <= 1'b0;
            NULL_PKT           <= 1'b0;
            NULL_DATA          <= '0;
        end else begin
            GIVE_ME_ONE_PACKET <= give_d;
            D_VALID_OUT        <= (state_d == ST_XFER);
            P_SYNC_OUT         <= (state_d == ST_XFER) && (byte_d == '0);
            NULL_PKT           <= null_act;
            NULL_DATA          <= null_act ? null_byte : 8'h00;
        end
    end

endmodule

// File: tb/tb_ts_packet_arbiter.sv
// tb_ts_packet_arbiter
// Scoreboard bench: each scenario pushes the channels it expects to be granted;
// a negedge monitor pops them on every GIVE pulse and checks packet framing.
// Null-packet scenario runs only when NULL_PKT_INSERT_EN is defined.
module tb_ts_packet_arbiter;

    localparam int N_CH     = 4;
    localparam int PKT_LEN  = 188;
    localparam int W_BITS   = 4;
    localparam int RD_LAT   = 2;
    localparam int NULL_GAP = 376;

    logic                   SYS_CLK = 1'b0;
    logic                   RST = 1'b0;
    logic [N_CH-1:0]        CH_EN = '0;
    logic [N_CH*W_BITS-1:0] WEIGHT = '0;
    logic [N_CH-1:0]        GOT_FULL_PACKET = '0;
    logic                   OUT_READY = 1'b0;
    logic [N_CH-1:0]        GIVE_ME_ONE_PACKET;
    logic [1:0]             SEL;
    logic                   D_VALID_OUT;
    logic                   P_SYNC_OUT;
    logic                   NULL_PKT;
    logic [7:0]             NULL_DATA;

    ts_packet_arbiter #(
        .N_CH(N_CH), .PKT_LEN(PKT_LEN), .W_BITS(W_BITS),
        .RD_LAT(RD_LAT), .NULL_GAP(NULL_GAP)
    ) dut (
        .SYS_CLK(SYS_CLK),
        .RST(RST),
        .CH_EN(CH_EN),
        .WEIGHT(WEIGHT),
        .GOT_FULL_PACKET(GOT_FULL_PACKET),
        .OUT_READY(OUT_READY),
        .GIVE_ME_ONE_PACKET(GIVE_ME_ONE_PACKET),
        .SEL(SEL),
        .D_VALID_OUT(D_VALID_OUT),
        .P_SYNC_OUT(P_SYNC_OUT),
        .NULL_PKT(NULL_PKT),
        .NULL_DATA(NULL_DATA)
    );

    initial forever #5 SYS_CLK = ~SYS_CLK;

    int checks = 0;
    int errors = 0;
    int cycle  = 0;
    int exp_q[$];

    bit in_pkt     = 1'b0;
    bit pkt_null   = 1'b0;
    int byte_cnt   = 0;
    int pkt_ch     = 0;
    int give_cycle = -1000;
    int last_byte  = -1000;
    int first_cycle = 0;

    always @(posedge SYS_CLK) cycle <= cycle + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cycle);
        end
    endtask

    function automatic logic [7:0] null_ref(input int idx);
        case (idx)
            0:       return 8'h47;
            1:       return 8'h1F;
            3:       return 8'h10;
            default: return 8'hFF;
        endcase
    endfunction

    // Monitor: pop expected grants on GIVE, check packet framing byte by byte.
    initial forever begin
        @(negedge SYS_CLK);
        if (!RST) begin
            in_pkt   = 1'b0;
            byte_cnt = 0;
        end else begin
            if (GIVE_ME_ONE_PACKET != '0) begin
                check("give_no_overlap", D_VALID_OUT, 0);
                check("give_after_gap", (cycle - last_byte) >= 3, 1);
                if (exp_q.size() == 0) begin
                    check("give_unexpected", GIVE_ME_ONE_PACKET, 0);
                end else begin
                    pkt_ch = exp_q.pop_front();
                    check("give_onehot", GIVE_ME_ONE_PACKET, 1 << pkt_ch);
                end
                give_cycle = cycle;
            end
            if (D_VALID_OUT) begin
                if (!in_pkt) begin
                    in_pkt      = 1'b1;
                    byte_cnt    = 0;
                    pkt_null    = NULL_PKT;
                    first_cycle = cycle;
                    if (!pkt_null) check("rd_lat", cycle - give_cycle, RD_LAT);
                end
                check("p_sync", P_SYNC_OUT, byte_cnt == 0);
                check("null_flag", NULL_PKT, pkt_null);
                if (pkt_null) check("null_data", NULL_DATA, null_ref(byte_cnt));
                else          check("sel_stable", SEL, pkt_ch);
                byte_cnt++;
                last_byte = cycle;
            end else begin
                check("p_sync_idle", P_SYNC_OUT, 0);
                if (in_pkt) begin
                    check("pkt_len", byte_cnt, PKT_LEN);
                    in_pkt = 1'b0;
                end
            end
        end
    end

    task automatic apply_reset();
        @(negedge SYS_CLK);
        #1 RST = 1'b0;
        #1;
        check("rst_give", GIVE_ME_ONE_PACKET, 0);
        check("rst_valid", D_VALID_OUT, 0);
        check("rst_sync", P_SYNC_OUT, 0);
        check("rst_sel", SEL, 0);
        check("rst_null", {NULL_PKT, NULL_DATA}, 0);
        exp_q.delete();
        repeat (3) @(negedge SYS_CLK);
        #1 RST = 1'b1;
    endtask

    // Wait for all expected grants, stop arbitration, let the last packet drain.
    task automatic run_grants(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge SYS_CLK); #1; n++;
        end
        check("grants_done", exp_q.size(), 0);
        exp_q.delete();
        OUT_READY = 1'b0;
        repeat (RD_LAT + 2) @(negedge SYS_CLK);
        #1;
        n = 0;
        while (in_pkt && n < PKT_LEN + 20) begin
            @(negedge SYS_CLK); #1; n++;
        end
        check("pkt_drained", in_pkt, 0);
    endtask

    task automatic wait_bytes(input int nb, input int budget);
        int n = 0;
        while (!(in_pkt && byte_cnt >= nb) && n < budget) begin
            @(negedge SYS_CLK); #1; n++;
        end
        check("reach_byte", in_pkt && byte_cnt >= nb, 1);
    endtask

    initial begin
        int rise;
        int seq1[9] = '{0, 1, 1, 2, 3, 3, 3, 0, 1};

        apply_reset();

        // Weighted sharing: weights 1,2,1,3 on channels 0..3.
        CH_EN = 4'b1111; GOT_FULL_PACKET = 4'b1111; WEIGHT = 16'h3121;
        foreach (seq1[i]) exp_q.push_back(seq1[i]);
        OUT_READY = 1'b1;
        run_grants(3000);

        // Masked channels with zero weights: alternate 1,3 with wrap.
        apply_reset();
        CH_EN = 4'b1010; GOT_FULL_PACKET = 4'b1111; WEIGHT = '0;
        exp_q.push_back(1); exp_q.push_back(3); exp_q.push_back(1); exp_q.push_back(3);
        OUT_READY = 1'b1;
        run_grants(2000);

        // Backpressure: no request while OUT_READY is low.
        apply_reset();
        CH_EN = 4'b1111; GOT_FULL_PACKET = 4'b0100;
        repeat (500) @(negedge SYS_CLK);
        #1;
        exp_q.push_back(2);
        rise = cycle;
        OUT_READY = 1'b1;
        run_grants(50);
        check("bp_give_lat", (give_cycle - rise) >= 1 && (give_cycle - rise) <= 2, 1);

        // Channel 0 disabled mid-packet: packet completes, never granted again.
        apply_reset();
        CH_EN = 4'b1001; GOT_FULL_PACKET = 4'b1111;
        exp_q.push_back(0);
        OUT_READY = 1'b1;
        wait_bytes(50, 300);
        CH_EN = 4'b1000;
        exp_q.push_back(3); exp_q.push_back(3);
        run_grants(1500);

        // Reset in the middle of a channel-3 packet, then restart from channel 0.
        apply_reset();
        CH_EN = 4'b1000; GOT_FULL_PACKET = 4'b1111;
        exp_q.push_back(3);
        OUT_READY = 1'b1;
        wait_bytes(100, 300);
        apply_reset();
        CH_EN = 4'b1001;
        exp_q.push_back(0);
        run_grants(600);

`ifdef NULL_PKT_INSERT_EN
        // Null insertion after NULL_GAP idle cycles; channel 1 waits for GAP.
        apply_reset();
        CH_EN = 4'b1111; GOT_FULL_PACKET = 4'b0000;
        rise = cycle;
        OUT_READY = 1'b1;
        wait_bytes(1, NULL_GAP + 50);
        check("null_pkt_seen", pkt_null, 1);
        check("null_gap", (first_cycle - rise) >= NULL_GAP && (first_cycle - rise) <= NULL_GAP + 2, 1);
        wait_bytes(50, 300);
        GOT_FULL_PACKET = 4'b0010;
        exp_q.push_back(1);
        run_grants(800);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

endmodule
